// File: rtl/ext_bus_if.sv
// ext_bus_if: CPU request/response and device select/acknowledge signals of ext_bus_ctrl.
// The shared DataBus stays a plain inout on the controller so the tristate resolves at one level.
interface ext_bus_if #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int NUM_DEV = 5
);
   logic [ADDR_W-1:0]  Addr;
   logic [DATA_W-1:0]  WriteData;
   logic               Read;
   logic               Write;
   logic               dev_ack;
   logic [NUM_DEV-1:0] CS;
   logic [DATA_W-1:0]  DataToCPU;
   logic               Ready;
   logic               bus_err;

   // CPU and external devices together: they issue requests and acknowledges.
   modport master (
      output Addr, WriteData, Read, Write, dev_ack,
      input  CS, DataToCPU, Ready, bus_err
   );

   // The controller: it takes requests and acknowledges, and drives selects and results.
   modport slave (
      input  Addr, WriteData, Read, Write, dev_ack,
      output CS, DataToCPU, Ready, bus_err
   );
endinterface

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: IDLE/ACCESS/DONE controller for NUM_DEV chip-selected devices plus a switch register.
// Define EXT_BUS_TIMEOUT_EN to force completion with bus_err after TIMEOUT ACCESS cycles without dev_ack.
module ext_bus_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int NUM_DEV = 5,
   parameter int SW_W    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SW_W-1:0]   switch,
   inout  wire  [DATA_W-1:0] DataBus,
   ext_bus_if.slave          bus
);

   // Reject parameter sets that would make the decode overlap or the counter meaningless.
   if (TIMEOUT < 1 || NUM_DEV < 1 || NUM_DEV >= (2**ADDR_W) - 1 || SW_W < 1 || SW_W > DATA_W) begin : g_bad_param
      $error("ext_bus_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [ADDR_W-1:0] SW_ADDR = ADDR_W'(NUM_DEV);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               is_wr_q, is_wr_d;
   logic [NUM_DEV-1:0] cs_q, cs_d;
   logic               drive_q, drive_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic [SW_W-1:0]    sw_meta_q, sw_meta_d;
   logic [SW_W-1:0]    sw_sync_q, sw_sync_d;

`ifdef EXT_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   logic               addr_is_dev;
   logic               addr_is_sw;
   logic               finish;
   logic [DATA_W-1:0]  sw_ext;

   assign addr_is_dev = (addr_q < SW_ADDR);
   assign addr_is_sw  = (addr_q == SW_ADDR);
   assign sw_ext      = DATA_W'(sw_sync_q);

   // Board switches are asynchronous; two flops before anything samples them.
   assign sw_meta_d = switch;
   assign sw_sync_d = sw_meta_q;

   // NOTE: every signal assigned in this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      cs_d    = cs_q;
      drive_d = drive_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      finish  = 1'b0;
`ifdef EXT_BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.Read || bus.Write) begin
               state_d = ACCESS;
               addr_d  = bus.Addr;
               wdata_d = bus.WriteData;
               is_wr_d = bus.Write;
               // Selects and the bus driver are registered so they are glitch-free in ACCESS.
               for (int i = 0; i < NUM_DEV; i++) begin
                  cs_d[i] = (bus.Addr == ADDR_W'(i));
               end
               drive_d = bus.Write && (bus.Addr < SW_ADDR);
`ifdef EXT_BUS_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end

         ACCESS: begin
            if (!addr_is_dev) begin
               // Switch register and unmapped space acknowledge on their own in one cycle.
               finish = 1'b1;
               err_d  = !addr_is_sw;
               if (!is_wr_q) begin
                  rdata_d = addr_is_sw ? sw_ext : '0;
               end
            end else if (bus.dev_ack) begin
               finish = 1'b1;
               if (!is_wr_q) begin
                  rdata_d = DataBus;
               end
            end
`ifdef EXT_BUS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               finish = 1'b1;
               err_d  = 1'b1;
               if (!is_wr_q) begin
                  rdata_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif

            if (finish) begin
               state_d = DONE;
               ready_d = 1'b1;
               cs_d    = '0;
               drive_d = 1'b0;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            cs_d    = '0;
            drive_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // the values from before this edge regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         cs_q      <= '0;
         drive_q   <= 1'b0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         cs_q      <= cs_d;
         drive_q   <= drive_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

`ifdef EXT_BUS_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign DataBus       = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign bus.CS        = cs_q;
   assign bus.DataToCPU = rdata_q;
   assign bus.Ready     = ready_q;
   assign bus.bus_err   = err_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl: directed checks of ext_bus_ctrl with hand-computed expectations.
// Honours EXT_BUS_TIMEOUT_EN the same way the design does.
module tb_ext_bus_ctrl;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 4;
   localparam int NUM_DEV = 5;
   localparam int SW_W    = 4;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [SW_W-1:0]   sw  = '0;
   wire  [DATA_W-1:0] data_bus;
   logic              dev_en   = 1'b0;
   logic [DATA_W-1:0] dev_data = '0;
   logic [DATA_W-1:0] exp_rd;

   int n_checks = 0;
   int n_errors = 0;

   assign data_bus = dev_en ? dev_data : {DATA_W{1'bz}};

   always #5 clk = ~clk;

   ext_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DEV(NUM_DEV)) bus ();

   ext_bus_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DEV(NUM_DEV), .SW_W(SW_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .switch  (sw),
      .DataBus (data_bus),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_req();
      bus.Read      = 1'b0;
      bus.Write     = 1'b0;
      bus.Addr      = '0;
      bus.WriteData = '0;
   endtask

   task automatic request(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
      bus.Read      = rd;
      bus.Write     = wr;
      bus.Addr      = a;
      bus.WriteData = wd;
   endtask

   initial begin
      clear_req();
      bus.dev_ack = 1'b0;

      // Reset state
      tick();
      check("rst_cs", 32'(bus.CS), 32'h0);
      check("rst_ready", 32'(bus.Ready), 32'h0);
      check("rst_err", 32'(bus.bus_err), 32'h0);
      check("rst_rdata", 32'(bus.DataToCPU), 32'h0);
      check("rst_bus_z", 32'(data_bus === 16'hzzzz), 32'h1);
      tick();
      rst = 1'b1;

      // Write to device 2, acknowledged in the first ACCESS cycle
      tick();
      request(1'b0, 1'b1, 4'd2, 16'hA5A5);
      tick();
      clear_req();
      check("wr_cs", 32'(bus.CS), 32'h04);
      check("wr_bus", 32'(data_bus), 32'hA5A5);
      check("wr_ready_early", 32'(bus.Ready), 32'h0);
      bus.dev_ack = 1'b1;
      tick();
      bus.dev_ack = 1'b0;
      check("wr_ready", 32'(bus.Ready), 32'h1);
      check("wr_err", 32'(bus.bus_err), 32'h0);
      check("wr_cs_done", 32'(bus.CS), 32'h0);
      check("wr_bus_z", 32'(data_bus === 16'hzzzz), 32'h1);
      check("wr_rdata_kept", 32'(bus.DataToCPU), 32'h0);

      // Read from device 0 with three wait cycles; a request during ACCESS is ignored
      tick();
      check("wr_ready_pulse", 32'(bus.Ready), 32'h0);
      request(1'b1, 1'b0, 4'd0, 16'h0);
      tick();
      clear_req();
      dev_en   = 1'b1;
      dev_data = 16'h1234;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("rd_cs_%0d", i), 32'(bus.CS), 32'h01);
         check($sformatf("rd_ready_%0d", i), 32'(bus.Ready), 32'h0);
         if (i == 1) request(1'b0, 1'b1, 4'd3, 16'hFFFF);
         if (i == 2) begin
            clear_req();
            check("rd_not_driven", 32'(data_bus), 32'h1234);
         end
         if (i == 4) bus.dev_ack = 1'b1;
         tick();
      end
      bus.dev_ack = 1'b0;
      dev_en      = 1'b0;
      check("rd_ready", 32'(bus.Ready), 32'h1);
      check("rd_data", 32'(bus.DataToCPU), 32'h1234);
      check("rd_err", 32'(bus.bus_err), 32'h0);
      check("rd_cs_done", 32'(bus.CS), 32'h0);
      tick();
      check("rd_ignored_req_cs", 32'(bus.CS), 32'h0);
      check("rd_ready_pulse", 32'(bus.Ready), 32'h0);

      // Switch register read through the synchronizer
      sw = 4'b1010;
      tick();
      tick();
      tick();
      request(1'b1, 1'b0, 4'd5, 16'h0);
      tick();
      clear_req();
      check("sw_cs", 32'(bus.CS), 32'h0);
      check("sw_ready_early", 32'(bus.Ready), 32'h0);
      tick();
      check("sw_ready", 32'(bus.Ready), 32'h1);
      check("sw_err", 32'(bus.bus_err), 32'h0);
      check("sw_data", 32'(bus.DataToCPU), 32'h000A);

      // Device 1 never acknowledges on its own
      tick();
      request(1'b1, 1'b0, 4'd1, 16'h0);
      tick();
      clear_req();
`ifdef EXT_BUS_TIMEOUT_EN
      for (int i = 1; i <= TIMEOUT; i++) begin
         check($sformatf("to_cs_%0d", i), 32'(bus.CS), 32'h02);
         check($sformatf("to_ready_%0d", i), 32'(bus.Ready), 32'h0);
         tick();
      end
      check("to_ready", 32'(bus.Ready), 32'h1);
      check("to_err", 32'(bus.bus_err), 32'h1);
      check("to_data", 32'(bus.DataToCPU), 32'h0);
      check("to_cs_done", 32'(bus.CS), 32'h0);
      exp_rd = 16'h0000;
`else
      dev_en   = 1'b1;
      dev_data = 16'hBEEF;
      for (int i = 1; i <= 20; i++) begin
         check($sformatf("wait_cs_%0d", i), 32'(bus.CS), 32'h02);
         check($sformatf("wait_ready_%0d", i), 32'(bus.Ready), 32'h0);
         if (i == 20) bus.dev_ack = 1'b1;
         tick();
      end
      bus.dev_ack = 1'b0;
      dev_en      = 1'b0;
      check("wait_ready", 32'(bus.Ready), 32'h1);
      check("wait_err", 32'(bus.bus_err), 32'h0);
      check("wait_data", 32'(bus.DataToCPU), 32'hBEEF);
      exp_rd = 16'hBEEF;
`endif

      // Read and Write together: the write wins
      tick();
      request(1'b1, 1'b1, 4'd3, 16'h3C3C);
      tick();
      clear_req();
      check("both_cs", 32'(bus.CS), 32'h08);
      check("both_bus", 32'(data_bus), 32'h3C3C);
      bus.dev_ack = 1'b1;
      tick();
      bus.dev_ack = 1'b0;
      check("both_ready", 32'(bus.Ready), 32'h1);
      check("both_rdata_kept", 32'(bus.DataToCPU), 32'(exp_rd));

      // Unmapped read
      tick();
      request(1'b1, 1'b0, 4'd9, 16'h0);
      tick();
      clear_req();
      check("unm_cs", 32'(bus.CS), 32'h0);
      check("unm_ready_early", 32'(bus.Ready), 32'h0);
      tick();
      check("unm_ready", 32'(bus.Ready), 32'h1);
      check("unm_err", 32'(bus.bus_err), 32'h1);
      check("unm_data", 32'(bus.DataToCPU), 32'h0);
      check("unm_cs_done", 32'(bus.CS), 32'h0);
      tick();
      check("unm_err_pulse", 32'(bus.bus_err), 32'h0);

      // Reset in the middle of a write, then a read straight after release
      request(1'b0, 1'b1, 4'd4, 16'h5A5A);
      tick();
      clear_req();
      check("mid_cs", 32'(bus.CS), 32'h10);
      check("mid_bus", 32'(data_bus), 32'h5A5A);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_cs", 32'(bus.CS), 32'h0);
      check("mid_rst_bus_z", 32'(data_bus === 16'hzzzz), 32'h1);
      check("mid_rst_ready", 32'(bus.Ready), 32'h0);
      tick();
      rst = 1'b1;
      request(1'b1, 1'b0, 4'd0, 16'h0);
      dev_en   = 1'b1;
      dev_data = 16'h0F0F;
      tick();
      clear_req();
      check("post_cs", 32'(bus.CS), 32'h01);
      bus.dev_ack = 1'b1;
      tick();
      bus.dev_ack = 1'b0;
      dev_en      = 1'b0;
      check("post_ready", 32'(bus.Ready), 32'h1);
      check("post_data", 32'(bus.DataToCPU), 32'h0F0F);
      check("post_err", 32'(bus.bus_err), 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
